// File: rtl/draw_paddle_ai_if.sv
//----------------------------------------------------------------------------
// Module : vga_if
// Brief  : VGA pixel-stream bundle: timing counters, syncs, blanks and colour.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

`default_nettype wire

// File: rtl/draw_paddle_ai.sv
//----------------------------------------------------------------------------
// Module : draw_paddle_ai
// Brief  : CPU paddle that paints a rectangle into the pixel stream and
//          tracks the ball. Optional hit flash via PADDLE_HIT_FLASH_EN.
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module draw_paddle_ai #(
  parameter int          X_POS        = 994,
  parameter int          WIDTH        = 15,
  parameter int          HEIGHT       = 100,
  parameter int          V_RES        = 768,
  parameter int          TICK_DIV     = 550000,
  parameter int          STEP         = 1,
  parameter int          DEADZONE     = 40,
  parameter logic [11:0] COLOR        = 12'hfff,
  parameter logic [11:0] FLASH_COLOR  = 12'hf00,
  parameter int          FLASH_FRAMES = 8
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        enable,
  input  wire logic [10:0] ball_y_pos,
  input  wire logic        ball_dir,
  input  wire logic        hit,
  output logic      [10:0] y_position,
  vga_if.in                vga,
  vga_if.out               vga_out
);

  localparam int          Y_MAX_I   = V_RES - HEIGHT;
  localparam int          Y_INIT_I  = Y_MAX_I / 2;
  localparam logic [11:0] Y_MAX     = 12'(Y_MAX_I);
  localparam logic [10:0] Y_INIT    = 11'(Y_INIT_I);
  localparam logic [11:0] HALF_H    = 12'(HEIGHT / 2);
  localparam logic [11:0] H_M1      = 12'(HEIGHT - 1);
  localparam logic [11:0] CENTER_T  = 12'(Y_INIT_I + HEIGHT / 2);
  localparam logic [11:0] DZ        = 12'(DEADZONE);
  localparam logic [11:0] STEP_W    = 12'(STEP);
  localparam logic [11:0] X_LO      = 12'(X_POS);
  localparam logic [11:0] X_HI      = 12'(X_POS + WIDTH - 1);
  localparam int          CNT_W     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRACK  = 2'd1,
    S_CENTER = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [10:0]      y_q, y_d;
  logic [10:0]      hcount_q, vcount_q;
  logic             hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0]      rgb_q, rgb_d;
  logic [11:0]      paint;
  logic             tick;

`ifdef PADDLE_HIT_FLASH_EN
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  logic [FW-1:0] flash_q, flash_d;
  logic          frame_start;

  always_comb begin
    frame_start = (vga.vcount == 11'd0) && (vga.hcount == 11'd0);
    flash_d     = flash_q;
    if (hit)
      flash_d = FW'(FLASH_FRAMES);
    else if (frame_start && (flash_q != '0))
      flash_d = flash_q - 1'b1;
    paint = (flash_q != '0) ? FLASH_COLOR : COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) flash_q <= '0;
    else     flash_q <= flash_d;
  end
`else
  logic unused_hit;
  logic [11:0] unused_flash_color;
  assign unused_hit         = hit;
  assign unused_flash_color = FLASH_COLOR;
  assign paint              = COLOR;
`endif

  always_comb begin
    tick  = (cnt_q == TICK_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = ball_dir ? S_TRACK : S_CENTER;
      end
      S_TRACK: begin
        if (!enable)       state_d = S_IDLE;
        else if (!ball_dir) state_d = S_CENTER;
      end
      S_CENTER: begin
        if (!enable)      state_d = S_IDLE;
        else if (ball_dir) state_d = S_TRACK;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // 12-bit working width keeps y+STEP and target+deadzone from wrapping.
  logic [11:0] y_ext, centre, target, dz, y_up;
  always_comb begin
    y_ext  = {1'b0, y_q};
    centre = y_ext + HALF_H;
    target = (state_q == S_TRACK) ? {1'b0, ball_y_pos} : CENTER_T;
    dz     = (state_q == S_TRACK) ? DZ : 12'd0;
    y_up   = y_ext + STEP_W;
    y_d    = y_q;
    if (tick && (state_q != S_IDLE)) begin
      if (target > centre + dz)
        y_d = (y_up > Y_MAX) ? Y_MAX[10:0] : y_up[10:0];
      else if (target + dz < centre)
        y_d = (y_ext >= STEP_W) ? (y_q - STEP_W[10:0]) : 11'd0;
    end
  end

  logic in_box;
  always_comb begin
    in_box = ({1'b0, vga.hcount} >= X_LO) && ({1'b0, vga.hcount} <= X_HI) &&
             ({1'b0, vga.vcount} >= y_ext) && ({1'b0, vga.vcount} <= y_ext + H_M1);
    rgb_d  = (in_box && !vga.hblnk && !vga.vblnk) ? paint : vga.rgb;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      y_q      <= Y_INIT;
      hcount_q <= '0;
      vcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      hblnk_q  <= 1'b0;
      vblnk_q  <= 1'b0;
      rgb_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      hcount_q <= vga.hcount;
      vcount_q <= vga.vcount;
      hsync_q  <= vga.hsync;
      vsync_q  <= vga.vsync;
      hblnk_q  <= vga.hblnk;
      vblnk_q  <= vga.vblnk;
      rgb_q    <= rgb_d;
    end
  end

  assign y_position     = y_q;
  assign vga_out.hcount = hcount_q;
  assign vga_out.vcount = vcount_q;
  assign vga_out.hsync  = hsync_q;
  assign vga_out.vsync  = vsync_q;
  assign vga_out.hblnk  = hblnk_q;
  assign vga_out.vblnk  = vblnk_q;
  assign vga_out.rgb    = rgb_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_paddle_ai.sv
//----------------------------------------------------------------------------
// Module : tb_draw_paddle_ai
// Brief  : Self-checking bench for draw_paddle_ai (STEP=1 and STEP=3 copies).
// Rev    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_draw_paddle_ai;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [10:0] ball_y_pos = '0;
  logic        ball_dir = 1'b0;
  logic        hit = 1'b0;
  logic [10:0] y1, y3;

  int checks = 0;
  int errors = 0;

  vga_if vga_in();
  vga_if vga_o1();
  vga_if vga_o3();

  always #5 clk = ~clk;

  draw_paddle_ai #(.TICK_DIV(4), .STEP(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .ball_y_pos(ball_y_pos),
    .ball_dir(ball_dir), .hit(hit), .y_position(y1), .vga(vga_in), .vga_out(vga_o1));

  draw_paddle_ai #(.TICK_DIV(4), .STEP(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable), .ball_y_pos(ball_y_pos),
    .ball_dir(ball_dir), .hit(hit), .y_position(y3), .vga(vga_in), .vga_out(vga_o3));

  // Reference: moves happen every 4th cycle after reset, driven by the
  // enable/direction seen on the previous edge.
  int          m_y1, m_y3, m_phase, m_flash;
  bit          m_en, m_dir;
  logic [11:0] e_rgb1, e_rgb3;
  logic [10:0] e_h, e_v;
  logic        e_hs, e_vs, e_hb, e_vb;

  function automatic bit box(int h, int v, int y);
    return (h >= 994) && (h <= 1008) && (v >= y) && (v <= y + 99);
  endfunction

  function automatic int move(int y, int s, bit dir, int ball);
    int t, dz, c;
    t  = dir ? ball : 384;
    dz = dir ? 40 : 0;
    c  = y + 50;
    if (t > c + dz)  return (y + s > 668) ? 668 : y + s;
    if (t + dz < c)  return (y - s < 0) ? 0 : y - s;
    return y;
  endfunction

  task automatic model_edge();
    logic [11:0] paint;
    if (rst) begin
      m_y1 = 334; m_y3 = 334; m_phase = 0; m_en = 0; m_dir = 0; m_flash = 0;
      e_rgb1 = 0; e_rgb3 = 0; e_h = 0; e_v = 0; e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
    end else begin
`ifdef PADDLE_HIT_FLASH_EN
      paint = (m_flash != 0) ? 12'hf00 : 12'hfff;
`else
      paint = 12'hfff;
`endif
      e_rgb1 = (box(vga_in.hcount, vga_in.vcount, m_y1) && !vga_in.hblnk && !vga_in.vblnk) ? paint : vga_in.rgb;
      e_rgb3 = (box(vga_in.hcount, vga_in.vcount, m_y3) && !vga_in.hblnk && !vga_in.vblnk) ? paint : vga_in.rgb;
      e_h = vga_in.hcount; e_v = vga_in.vcount; e_hs = vga_in.hsync;
      e_vs = vga_in.vsync; e_hb = vga_in.hblnk; e_vb = vga_in.vblnk;
      if (m_phase == 3 && m_en) begin
        m_y1 = move(m_y1, 1, m_dir, int'(ball_y_pos));
        m_y3 = move(m_y3, 3, m_dir, int'(ball_y_pos));
      end
      m_phase = (m_phase + 1) % 4;
      m_en = enable; m_dir = ball_dir;
      if (hit) m_flash = 8;
      else if (vga_in.hcount == 0 && vga_in.vcount == 0 && m_flash > 0) m_flash--;
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_pixel(int h, int v, bit hb, bit vb, logic [11:0] rgb);
    vga_in.hcount = 11'(h); vga_in.vcount = 11'(v);
    vga_in.hblnk = hb; vga_in.vblnk = vb; vga_in.rgb = rgb;
    vga_in.hsync = 1'($urandom); vga_in.vsync = 1'($urandom);
  endtask

  task automatic rand_pixel();
    int v;
    v = m_y1 + int'($urandom_range(0, 120)) - 10;
    if (v < 0) v = 0;
    set_pixel($urandom_range(985, 1015), v, ($urandom % 8) == 0, ($urandom % 8) == 0,
              12'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_pixel(994, 334, 1'b1, 1'b1, 12'h5a5);
    vga_in.hsync = 1'b1; vga_in.vsync = 1'b1;
    for (int i = 0; i < 3; i++) clk_step();
    checks++;
    if (y1 !== 11'd334) begin errors++; $display("FAIL reset_y got %0d want 334", y1); end
    checks++;
    if ({vga_o1.hcount, vga_o1.vcount, vga_o1.hsync, vga_o1.vsync, vga_o1.hblnk, vga_o1.vblnk, vga_o1.rgb} !== '0) begin
      errors++; $display("FAIL reset_vga got h=%0d v=%0d rgb=%h want all 0", vga_o1.hcount, vga_o1.vcount, vga_o1.rgb);
    end
  endtask

  task automatic test_video();
    rst = 1'b0;
    set_pixel(994, 334, 1'b0, 1'b0, 12'h123);
    clk_step();
    checks++;
    if (vga_o1.rgb !== 12'hfff) begin errors++; $display("FAIL video_corner got %h want fff", vga_o1.rgb); end
    set_pixel(1009, 334, 1'b0, 1'b0, 12'h123);
    clk_step();
    checks++;
    if (vga_o1.rgb !== 12'h123) begin errors++; $display("FAIL video_right_edge got %h want 123", vga_o1.rgb); end
    set_pixel(1008, 433, 1'b0, 1'b0, 12'h456);
    clk_step();
    checks++;
    if (vga_o1.rgb !== 12'hfff) begin errors++; $display("FAIL video_far_corner got %h want fff", vga_o1.rgb); end
    for (int i = 0; i < 60; i++) begin
      rand_pixel();
      clk_step();
      checks++;
      if ({vga_o1.hcount, vga_o1.vcount, vga_o1.hsync, vga_o1.vsync, vga_o1.hblnk, vga_o1.vblnk, vga_o1.rgb} !==
          {e_h, e_v, e_hs, e_vs, e_hb, e_vb, e_rgb1}) begin
        errors++; $display("FAIL video_rand got h=%0d v=%0d rgb=%h want h=%0d v=%0d rgb=%h",
                           vga_o1.hcount, vga_o1.vcount, vga_o1.rgb, e_h, e_v, e_rgb1);
      end
    end
  endtask

  task automatic run_motion(string name, int n);
    for (int i = 0; i < n; i++) begin
      rand_pixel();
      clk_step();
      checks++;
      if (y1 !== 11'(m_y1) || y3 !== 11'(m_y3)) begin
        errors++; $display("FAIL %s_y got %0d/%0d want %0d/%0d", name, y1, y3, m_y1, m_y3);
      end
      checks++;
      if (vga_o1.rgb !== e_rgb1 || vga_o3.rgb !== e_rgb3) begin
        errors++; $display("FAIL %s_rgb got %h/%h want %h/%h", name, vga_o1.rgb, vga_o3.rgb, e_rgb1, e_rgb3);
      end
    end
  endtask

  task automatic test_track();
    enable = 1'b1; ball_dir = 1'b1; ball_y_pos = 11'd700;
    run_motion("track", 1200);
    checks++;
    if (y1 !== 11'd610 || y3 !== 11'd610) begin errors++; $display("FAIL track_stop got %0d/%0d want 610", y1, y3); end
  endtask

  task automatic test_center();
    ball_dir = 1'b0;
    run_motion("center", 1200);
    checks++;
    if (y1 !== 11'd334 || y3 !== 11'd334) begin errors++; $display("FAIL center_settle got %0d/%0d want 334", y1, y3); end
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ball_dir = 1'($urandom); ball_y_pos = 11'($urandom_range(0, 1500));
      run_motion("idle", 4);
    end
    checks++;
    if (y1 !== 11'd334) begin errors++; $display("FAIL idle_frozen got %0d want 334", y1); end
  endtask

  task automatic test_clamp();
    enable = 1'b1; ball_dir = 1'b1; ball_y_pos = 11'd2000;
    run_motion("clamp_bot", 1400);
    checks++;
    if (y1 !== 11'd668 || y3 !== 11'd668) begin errors++; $display("FAIL clamp_bottom got %0d/%0d want 668", y1, y3); end
    ball_y_pos = 11'd0;
    run_motion("clamp_top", 2800);
    checks++;
    if (y1 !== 11'd0 || y3 !== 11'd0) begin errors++; $display("FAIL clamp_top got %0d/%0d want 0", y1, y3); end
  endtask

  task automatic test_rst_mid();
    ball_y_pos = 11'd700;
    for (int i = 0; i < 3000 && m_y1 != 500; i++) run_motion("to500", 1);
    checks++;
    if (y1 !== 11'd500) begin errors++; $display("FAIL reach_500 got %0d want 500", y1); end
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    checks++;
    if (y1 !== 11'd334 || vga_o1.rgb !== 12'h000) begin
      errors++; $display("FAIL rst_mid got y=%0d rgb=%h want y=334 rgb=000", y1, vga_o1.rgb);
    end
    for (int i = 0; i < 3; i++) clk_step();
    checks++;
    if (y1 !== 11'd334) begin errors++; $display("FAIL rst_tick_early got %0d want 334", y1); end
    clk_step();
    checks++;
    if (y1 !== 11'd335) begin errors++; $display("FAIL rst_tick_first got %0d want 335", y1); end
  endtask

  task automatic test_flash();
    logic [11:0] want;
    enable = 1'b0;
    for (int f = 0; f < 12; f++) begin
      hit = (f == 0) || (f == 5);
      set_pixel(0, 0, 1'b1, 1'b1, 12'h000);
      clk_step();
      hit = 1'b0;
      set_pixel(1000, m_y1 + 10, 1'b0, 1'b0, 12'h0a0);
      clk_step();
`ifdef PADDLE_HIT_FLASH_EN
      want = (f < 12) ? 12'hf00 : 12'hfff;
`else
      want = 12'hfff;
`endif
      checks++;
      if (vga_o1.rgb !== want || vga_o1.rgb !== e_rgb1) begin
        errors++; $display("FAIL flash_f%0d got %h want %h", f, vga_o1.rgb, want);
      end
    end
    for (int f = 0; f < 2; f++) begin
      set_pixel(0, 0, 1'b1, 1'b1, 12'h000);
      clk_step();
      set_pixel(1000, m_y1 + 10, 1'b0, 1'b0, 12'h0a0);
      clk_step();
    end
    checks++;
    if (vga_o1.rgb !== 12'hfff) begin errors++; $display("FAIL flash_expired got %h want fff", vga_o1.rgb); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom % 10) != 0;
      if (($urandom % 50) == 0) ball_dir = ~ball_dir;
      if (($urandom % 20) == 0) ball_y_pos = 11'($urandom_range(0, 2047));
      hit        = ($urandom % 97) == 0;
      run_motion("random", 1);
      if (($urandom % 15) == 0) set_pixel(0, 0, 1'b0, 1'b0, 12'h777);
    end
    hit = 1'b0;
  endtask

  initial begin
    set_pixel(0, 1, 1'b0, 1'b0, 12'h000);
    test_reset();
    test_video();
    test_track();
    test_center();
    test_clamp();
    test_rst_mid();
    test_flash();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
